// File: rtl/uart_loader.sv
`default_nettype none
// ---- uart_loader : UART 8N1 receiver feeding a length-prefixed program image into RAM -------
// ---- optional trailing checksum byte: UART_LOADER_CHECKSUM_EN            | rev 1.0 ---------
module uart_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] addr_bus,
  output logic [7:0]        wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              error,
  output logic [7:0]        byte_count
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef UART_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {L_LEN, L_DATA, L_SUM, L_DONE, L_ERR} ld_state_t;
`else
  typedef enum logic [2:0] {L_LEN, L_DATA, L_DONE, L_ERR} ld_state_t;
`endif

  rx_state_t     r_rx_state, w_rx_next;
  ld_state_t     r_l_state, w_l_next;
  logic          r_rx_meta, r_rx_sync;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_rx_valid, r_rx_ferr;
  logic          w_tick;
  logic          r_wr_enable;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]    r_wdata, r_byte_count;
  logic [8:0]    r_remaining;
  logic          w_latch_len, w_do_write;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]    r_sum;
`endif

  // w_tick marks the sample point of the current bit phase
  always_comb begin
    w_rx_next = r_rx_state;
    w_tick    = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
      RX_START: if (r_clk_cnt == HALF_LAST) begin
        w_tick    = 1'b1;
        w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA:  if (r_clk_cnt == BIT_LAST) begin
        w_tick = 1'b1;
        if (r_bit_idx == 3'd7) w_rx_next = RX_STOP;
      end
      RX_STOP:  if (r_clk_cnt == BIT_LAST) begin
        w_tick    = 1'b1;
        w_rx_next = RX_IDLE;
      end
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rx_state <= RX_IDLE;
    else       r_rx_state <= w_rx_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_meta  <= rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      if (w_tick || r_rx_state == RX_IDLE) r_clk_cnt <= '0;
      else                                 r_clk_cnt <= r_clk_cnt + CW'(1);
      if (r_rx_state == RX_START) r_bit_idx <= '0;
      if (r_rx_state == RX_DATA && w_tick) begin
        r_shift   <= {r_rx_sync, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (r_rx_state == RX_STOP && w_tick) begin
        r_rx_valid <= r_rx_sync;
        r_rx_ferr  <= !r_rx_sync;
      end
    end
  end

  // Completion is checked the cycle the last write strobe is high, so cpu_run follows it.
  always_comb begin
    w_l_next    = r_l_state;
    w_latch_len = 1'b0;
    w_do_write  = 1'b0;
    case (r_l_state)
      L_LEN: begin
        if (r_rx_ferr) w_l_next = L_ERR;
        else if (r_rx_valid) begin
          w_latch_len = 1'b1;
          w_l_next    = L_DATA;
        end
      end
      L_DATA: begin
        if (r_wr_enable && r_remaining == 9'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
          w_l_next = L_SUM;
`else
          w_l_next = L_DONE;
`endif
        end else if (r_rx_ferr) w_l_next = L_ERR;
        else if (r_rx_valid) w_do_write = 1'b1;
      end
`ifdef UART_LOADER_CHECKSUM_EN
      L_SUM: begin
        if (r_rx_ferr) w_l_next = L_ERR;
        else if (r_rx_valid) w_l_next = (r_shift == r_sum) ? L_DONE : L_ERR;
      end
`endif
      default: w_l_next = r_l_state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_l_state <= L_LEN;
    else       r_l_state <= w_l_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_enable  <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_byte_count <= '0;
      r_remaining  <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      r_wr_enable <= 1'b0;
      if (w_latch_len) r_remaining <= (r_shift == 8'd0) ? 9'd256 : {1'b0, r_shift};
      if (w_do_write) begin
        r_wr_enable  <= 1'b1;
        r_addr       <= ADDR_W'(r_byte_count);
        r_wdata      <= r_shift;
        r_byte_count <= r_byte_count + 8'd1;
        r_remaining  <= r_remaining - 9'd1;
`ifdef UART_LOADER_CHECKSUM_EN
        r_sum        <= r_sum + r_shift;
`endif
      end
    end
  end

  assign wr_enable  = r_wr_enable;
  assign addr_bus   = r_addr;
  assign wdata      = r_wdata;
  assign byte_count = r_byte_count;
  assign cpu_run    = (r_l_state == L_DONE);
  assign error      = (r_l_state == L_ERR);
`ifdef UART_LOADER_CHECKSUM_EN
  assign busy       = (r_l_state == L_DATA) || (r_l_state == L_SUM);
`else
  assign busy       = (r_l_state == L_DATA);
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// tb_uart_loader: directed + random image loads against a queue-based model of the loader.
module tb_uart_loader;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       wr_enable, cpu_run, busy, error;
  logic [7:0] addr_bus, wdata, byte_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] act_q[$];
  logic        prev_we = 1'b0;

  always #5 clk = ~clk;

  uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .wr_enable(wr_enable), .addr_bus(addr_bus), .wdata(wdata),
    .cpu_run(cpu_run), .busy(busy), .error(error), .byte_count(byte_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_enable === 1'b1) begin
      act_q.push_back({addr_bus, wdata});
      check("we_gap", {31'b0, prev_we}, 32'd0);
      check("we_busy", {31'b0, busy}, 32'd1);
    end
    prev_we = wr_enable;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(CPB); end
    rx = stop_bit; tick(CPB);
    rx = 1'b1;
    if (!stop_bit) tick(CPB);
  endtask

  task automatic do_reset;
    rx = 1'b1; reset = 1'b1;
    tick(3);
    reset = 1'b0;
    act_q.delete();
    tick(2);
  endtask

  task automatic check_out(input string tag, input logic [15:0] exp_q[$],
                           input logic [7:0] exp_bc, input logic exp_run, input logic exp_err);
    check({tag, "_nwrites"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check({tag, "_write"}, act_q[i], exp_q[i]);
    check({tag, "_byte_count"}, byte_count, exp_bc);
    check({tag, "_cpu_run"}, cpu_run, exp_run);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Model: every data byte lands at its index; result depends only on checksum correctness.
  task automatic run_image(input string tag, input logic [7:0] img[$],
                           input logic [7:0] sum_delta, input logic glitch);
    logic [7:0]  sum;
    logic [15:0] exp_q[$];
    logic        ok;
    sum = 8'd0;
    ok  = 1'b1;
    do_reset();
    if (glitch) begin rx = 1'b0; tick(3); rx = 1'b1; tick(2 * CPB); end
    send_byte(8'(img.size()));
    foreach (img[i]) begin
      send_byte(img[i]);
      sum = sum + img[i];
      exp_q.push_back({8'(i), img[i]});
    end
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(sum + sum_delta);
    ok = (sum_delta == 8'd0);
`endif
    tick(2 * CPB);
    check_out(tag, exp_q, 8'(img.size()), ok, !ok);
  endtask

  initial begin
    logic [7:0]  img[$];
    logic [15:0] exp_q[$];

    do_reset();
    check("rst_outputs", {wr_enable, addr_bus, wdata, cpu_run, busy, error, byte_count}, 0);
    tick(10000);
    check("idle_outputs", {wr_enable, addr_bus, wdata, cpu_run, busy, error, byte_count}, 0);
    check("idle_nwrites", act_q.size(), 0);

    img = '{8'h01, 8'h05, 8'h0A};
    run_image("three", img, 8'd0, 1'b0);

    img.delete();
    for (int i = 0; i < 256; i++) img.push_back(8'(i));
    run_image("full256", img, 8'd0, 1'b0);

    do_reset();
    send_byte(8'h02); send_byte(8'h11);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h55);
    tick(2 * CPB);
    exp_q = '{16'h0011};
    check_out("ferr", exp_q, 8'd1, 1'b0, 1'b1);

    img = '{8'h42};
    run_image("glitch", img, 8'd0, 1'b1);

    for (int t = 0; t < 3; t++) begin
      img.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) img.push_back(8'($urandom));
      run_image("random", img, 8'd0, 1'b0);
    end

`ifdef UART_LOADER_CHECKSUM_EN
    img = '{8'h10, 8'h20};
    run_image("sum_bad", img, 8'd1, 1'b0);
    run_image("sum_good", img, 8'd0, 1'b0);
    img.delete();
    for (int i = 0; i < 5; i++) img.push_back(8'($urandom));
    run_image("sum_rand_bad", img, 8'($urandom_range(1, 255)), 1'b0);
`endif

    do_reset();
    send_byte(8'h02); send_byte(8'h10);
    tick(2 * CPB);
    check("midrst_busy", busy, 1);
    check("midrst_bc", byte_count, 1);
    rx = 1'b0;
    tick(30);
    #2 reset = 1'b1;
    #1 check("midrst_async", {wr_enable, addr_bus, wdata, cpu_run, busy, error, byte_count}, 0);
    tick(3);
    rx = 1'b1;
    reset = 1'b0;
    tick(4 * CPB);
    check("midrst_after", {wr_enable, addr_bus, wdata, cpu_run, busy, error, byte_count}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
